// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg -- shared definitions for the VGA timing receiver.
//   rx_state_t : lock state machine encoding (SEARCH, WAIT_VS, LOCKED)
//   *_DEF      : default 640x480-style timing (800 clk/line, 526 lines/frame)
//   CNT_MAX    : saturation value of the 10-bit line/pixel counters
//   sat_inc()  : 10-bit increment that sticks at CNT_MAX
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    WAIT_VS = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned V_TOTAL_DEF     = 526;
  localparam int unsigned H_SYNC_W        = 96;
  localparam int unsigned V_SYNC_W        = 2;
  localparam int unsigned H_ACT_START_DEF = 145;
  localparam int unsigned H_ACT_W_DEF     = 639;
  localparam int unsigned V_ACT_START_DEF = 36;
  localparam int unsigned V_ACT_H_DEF     = 479;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  function automatic logic [9:0] sat_inc(input logic [9:0] val);
    return (val == CNT_MAX) ? CNT_MAX : val + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det -- rising-edge detector for one sync input.
//   clk  : pixel clock
//   rst  : asynchronous active-high reset (clears synchronizer and history)
//   din  : raw sync level
//   rise : high for the one sample in which the (optionally synchronized)
//          level goes 0 -> 1, measured against a registered history bit
// Build option: VGA_RX_INPUT_SYNC_EN inserts a 2-flop synchronizer ahead of
// the detector; without it the input is used directly.
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sample;
  logic hist_reg;

`ifdef VGA_RX_INPUT_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], din};
  end

  assign sample = sync_reg[1];
`else
  assign sample = din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_reg <= 1'b0;
    else     hist_reg <= sample;
  end

  // A held-high level produces a single pulse, so long sync pulses count once.
  assign rise = sample & ~hist_reg;

endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx -- measures incoming VGA sync timing, locks onto a stable
// raster and emits active-area pixel coordinates and colour.
//   clk                      : 25 MHz pixel clock
//   rst                      : asynchronous active-high reset
//   i_hsync/i_vsync          : active-high syncs
//   i_red/i_green/i_blue     : 1-bit colour samples
//   o_pix_valid              : pixel inside active window while locked
//   o_pix_x/o_pix_y          : 0-based active-area coordinates
//   o_red/o_green/o_blue     : colour, zero when o_pix_valid=0
//   o_locked                 : timing lock indicator
//   o_frame_start            : pulse on each vsync rise while locked
//   o_sync_err               : pulse on each detected timing violation
//   o_line_len               : last measured line length (saturating)
// Build option: VGA_RX_INPUT_SYNC_EN adds 2-flop synchronizers on all five
// inputs (3 clk latency); default build samples inputs directly (1 clk).
module vga_timing_rx
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned H_ACT_START = H_ACT_START_DEF,
  parameter int unsigned H_ACT_W     = H_ACT_W_DEF,
  parameter int unsigned V_ACT_START = V_ACT_START_DEF,
  parameter int unsigned V_ACT_H     = V_ACT_H_DEF,
  parameter int unsigned LOCK_LINES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_red,
  input  logic       i_green,
  input  logic       i_blue,
  output logic       o_pix_valid,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic       o_red,
  output logic       o_green,
  output logic       o_blue,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_sync_err,
  output logic [9:0] o_line_len
);

  localparam int LCW = $clog2(LOCK_LINES + 1);

  logic           hs_rise, vs_rise;
  logic [2:0]     rgb_smp;
  rx_state_t      state_reg, state_next;
  logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
  logic           seen_hs_reg;
  logic [9:0]     h_cnt_reg, v_cnt_reg;
  logic [9:0]     h_inc, h_now, v_now;
  logic           line_ok, in_win, pix_valid_next;
  logic           frame_start_next, sync_err_next;

  vga_edge_det u_hs_edge (.clk(clk), .rst(rst), .din(i_hsync), .rise(hs_rise));
  vga_edge_det u_vs_edge (.clk(clk), .rst(rst), .din(i_vsync), .rise(vs_rise));

`ifdef VGA_RX_INPUT_SYNC_EN
  // Colour goes through the same two stages as the syncs so they stay aligned.
  logic [2:0] rgb_s1_reg, rgb_s2_reg;
  logic [2:0] rgb_in;
  assign rgb_in = {i_red, i_green, i_blue};

  for (genvar gi = 0; gi < 3; gi++) begin : g_rgb_sync
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rgb_s1_reg[gi] <= 1'b0;
        rgb_s2_reg[gi] <= 1'b0;
      end else begin
        rgb_s1_reg[gi] <= rgb_in[gi];
        rgb_s2_reg[gi] <= rgb_s1_reg[gi];
      end
    end
  end

  assign rgb_smp = rgb_s2_reg;
`else
  assign rgb_smp = {i_red, i_green, i_blue};
`endif

  // Counter values belonging to the sample being taken this cycle; the
  // registered outputs are derived from these so latency is one clock.
  assign h_inc   = sat_inc(h_cnt_reg);
  assign h_now   = hs_rise ? 10'd0 : h_inc;
  assign v_now   = vs_rise ? 10'd0 : (hs_rise ? sat_inc(v_cnt_reg) : v_cnt_reg);
  assign line_ok = (h_inc == 10'(H_TOTAL));

  assign in_win = (h_now >= 10'(H_ACT_START)) && (h_now < 10'(H_ACT_START + H_ACT_W)) &&
                  (v_now >= 10'(V_ACT_START)) && (v_now < 10'(V_ACT_START + V_ACT_H));

  always_comb begin
    state_next       = state_reg;
    lock_cnt_next    = lock_cnt_reg;
    frame_start_next = 1'b0;
    sync_err_next    = 1'b0;
    case (state_reg)
      SEARCH: begin
        // The first hsync after reset closes no complete line, so skip it.
        if (hs_rise && seen_hs_reg) begin
          if (!line_ok) begin
            lock_cnt_next = '0;
            sync_err_next = 1'b1;
          end else if (lock_cnt_reg == LCW'(LOCK_LINES - 1)) begin
            lock_cnt_next = '0;
            state_next    = WAIT_VS;
          end else begin
            lock_cnt_next = lock_cnt_reg + LCW'(1);
          end
        end
      end
      WAIT_VS: begin
        if (hs_rise && !line_ok) begin
          state_next    = SEARCH;
          sync_err_next = 1'b1;
        end else if (vs_rise) begin
          state_next       = LOCKED;
          frame_start_next = 1'b1;
        end
      end
      LOCKED: begin
        if ((hs_rise && !line_ok) || (h_now == CNT_MAX) ||
            (vs_rise && (v_cnt_reg != 10'(V_TOTAL - 1)))) begin
          state_next    = SEARCH;
          lock_cnt_next = '0;
          sync_err_next = 1'b1;
        end else if (vs_rise) begin
          frame_start_next = 1'b1;
        end
      end
      default: begin
        state_next    = SEARCH;
        lock_cnt_next = '0;
      end
    endcase
  end

  assign pix_valid_next = in_win && (state_next == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SEARCH;
      lock_cnt_reg  <= '0;
      seen_hs_reg   <= 1'b0;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      o_pix_valid   <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_red         <= 1'b0;
      o_green       <= 1'b0;
      o_blue        <= 1'b0;
      o_locked      <= 1'b0;
      o_frame_start <= 1'b0;
      o_sync_err    <= 1'b0;
      o_line_len    <= '0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      seen_hs_reg   <= seen_hs_reg | hs_rise;
      h_cnt_reg     <= h_now;
      v_cnt_reg     <= v_now;
      o_pix_valid   <= pix_valid_next;
      o_pix_x       <= in_win ? (h_now - 10'(H_ACT_START)) : 10'd0;
      o_pix_y       <= in_win ? (v_now - 10'(V_ACT_START)) : 10'd0;
      {o_red, o_green, o_blue} <= pix_valid_next ? rgb_smp : 3'b000;
      o_locked      <= (state_next == LOCKED);
      o_frame_start <= frame_start_next;
      o_sync_err    <= sync_err_next;
      if (hs_rise) o_line_len <= h_inc;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx -- self-checking bench for vga_timing_rx (default build).
// Horizontal timing uses the real 800-clock line; the frame is shortened to
// 8 lines so that several lock/unlock cycles fit in a short run.
module tb_vga_timing_rx;
  import vga_rx_pkg::*;

  localparam int HT  = H_TOTAL_DEF;
  localparam int HAS = H_ACT_START_DEF;
  localparam int HAW = H_ACT_W_DEF;
  localparam int VT  = 8;
  localparam int VAS = 2;
  localparam int VAH = 3;
  localparam int FR  = HT * VT;
  localparam int NV  = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_hsync = 1'b0, i_vsync = 1'b0;
  logic       i_red = 1'b0, i_green = 1'b0, i_blue = 1'b0;
  logic       o_pix_valid, o_red, o_green, o_blue;
  logic       o_locked, o_frame_start, o_sync_err;
  logic [9:0] o_pix_x, o_pix_y, o_line_len;

  int n_checks = 0;
  int n_fail   = 0;
  int err_acc  = 0;

  vga_timing_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT_W(HAW),
    .V_ACT_START(VAS), .V_ACT_H(VAH), .LOCK_LINES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_locked(o_locked), .o_frame_start(o_frame_start),
    .o_sync_err(o_sync_err), .o_line_len(o_line_len)
  );

  always #20 clk = ~clk;

  typedef struct {
    int         v;
    int         h;
    logic [2:0] rgb;
    logic       ev;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [2:0] ergb;
  } vec_t;

  vec_t vec [NV];

  function automatic logic [36:0] outs();
    return {o_pix_valid, o_pix_x, o_pix_y, o_red, o_green, o_blue,
            o_locked, o_frame_start, o_sync_err, o_line_len};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one sample between edges; outputs for it are visible on return.
  task automatic tick(input logic hs, input logic vs, input logic [2:0] rgb);
    i_hsync = hs;
    i_vsync = vs;
    {i_red, i_green, i_blue} = rgb;
    @(negedge clk);
    if (o_sync_err) err_acc++;
  endtask

  // Samples h0..h1-1 of source line v with random colour.
  task automatic span(input int v, input int h0, input int h1);
    for (int h = h0; h < h1; h++)
      tick(h < H_SYNC_W, v < V_SYNC_W, 3'($urandom));
  endtask

  initial begin
    logic [36:0] exp;
    logic [2:0]  rgb;
    logic        win, lk, hit;
    int          h, v, e0, ti;

    vec[0]  = '{1, 200, 3'd7, 1'b0, 10'd0,   10'd0, 3'd0};
    vec[1]  = '{2, 0,   3'd7, 1'b0, 10'd0,   10'd0, 3'd0};
    vec[2]  = '{2, 144, 3'd7, 1'b0, 10'd0,   10'd0, 3'd0};
    vec[3]  = '{2, 145, 3'd7, 1'b1, 10'd0,   10'd0, 3'd7};
    vec[4]  = '{2, 146, 3'd5, 1'b1, 10'd1,   10'd0, 3'd5};
    vec[5]  = '{2, 783, 3'd3, 1'b1, 10'd638, 10'd0, 3'd3};
    vec[6]  = '{2, 784, 3'd7, 1'b0, 10'd0,   10'd0, 3'd0};
    vec[7]  = '{3, 400, 3'd2, 1'b1, 10'd255, 10'd1, 3'd2};
    vec[8]  = '{4, 145, 3'd4, 1'b1, 10'd0,   10'd2, 3'd4};
    vec[9]  = '{4, 783, 3'd1, 1'b1, 10'd638, 10'd2, 3'd1};
    vec[10] = '{5, 145, 3'd7, 1'b0, 10'd0,   10'd0, 3'd0};
    vec[11] = '{6, 500, 3'd6, 1'b0, 10'd0,   10'd0, 3'd0};

    // Reset: outputs stay zero whatever the inputs do.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      tick(k[0], k[1], 3'b111);
      chk("reset_outputs", 64'(outs()), 64'd0);
    end
    rst = 1'b0;

    // Frames 0-1: ideal raster with random colour against an arithmetic model.
    for (int n = 0; n < 2 * FR; n++) begin
      h   = n % HT;
      v   = (n / HT) % VT;
      rgb = 3'($urandom);
      tick(h < H_SYNC_W, v < V_SYNC_W, rgb);
      lk  = (n >= FR);
      win = (h >= HAS) && (h < HAS + HAW) && (v >= VAS) && (v < VAS + VAH);
      exp = {win && lk, win ? 10'(h - HAS) : 10'd0, win ? 10'(v - VAS) : 10'd0,
             (win && lk) ? rgb : 3'b000, lk, lk && (n % FR == 0), 1'b0,
             (n < HT) ? 10'd1 : 10'(HT)};
      chk("model_stream", 64'(outs()), 64'(exp));
    end

    // Frame 2: table of pixel probes inside a locked raster.
    ti = 0;
    for (int vv = 0; vv < VT; vv++) begin
      for (int hh = 0; hh < HT; hh++) begin
        hit = 1'b0;
        rgb = 3'($urandom);
        if (ti < NV && vec[ti].v == vv && vec[ti].h == hh) begin
          hit = 1'b1;
          rgb = vec[ti].rgb;
        end
        tick(hh < H_SYNC_W, vv < V_SYNC_W, rgb);
        if (hit) begin
          chk($sformatf("pixel_v%0d_h%0d", vv, hh),
              64'({o_pix_valid, o_pix_x, o_pix_y, o_red, o_green, o_blue}),
              64'({vec[ti].ev, vec[ti].ex, vec[ti].ey, vec[ti].ergb}));
          ti++;
        end
      end
    end

    // Frame 3: one 799-clock line, then relock at frame 4.
    e0 = err_acc;
    span(0, 0, HT);
    span(1, 0, HT - 1);
    span(2, 0, 1);
    chk("short_line_err", 64'(o_sync_err), 64'd1);
    chk("short_line_unlock", 64'(o_locked), 64'd0);
    chk("short_line_len", 64'(o_line_len), 64'(HT - 1));
    span(2, 1, HT);
    for (int vv = 3; vv < VT; vv++) span(vv, 0, HT);
    chk("short_line_wait_vs", 64'(o_locked), 64'd0);
    span(0, 0, 1);
    chk("short_line_relock", 64'(o_locked), 64'd1);
    chk("short_line_relock_fs", 64'(o_frame_start), 64'd1);
    chk("short_line_err_count", 64'(err_acc - e0), 64'd1);

    // Frame 4: hsync absent for 1100 clocks on line 1.
    span(0, 1, HT);
    e0 = err_acc;
    span(1, 0, 1023);
    chk("sat_locked_at_1022", 64'(o_locked), 64'd1);
    span(1, 1023, 1024);
    chk("sat_err", 64'(o_sync_err), 64'd1);
    chk("sat_unlock", 64'(o_locked), 64'd0);
    span(1, 1024, 1100);
    chk("sat_err_once", 64'(err_acc - e0), 64'd1);
    span(2, 0, 1);
    chk("sat_line_len", 64'(o_line_len), 64'd1023);
    span(2, 1, HT);
    for (int vv = 3; vv < VT; vv++) span(vv, 0, HT);
    span(0, 0, 1);
    chk("sat_relock", 64'(o_locked), 64'd1);

    // Frame 5: one line short, vsync arrives early.
    span(0, 1, HT);
    for (int vv = 1; vv < VT - 1; vv++) span(vv, 0, HT);
    e0 = err_acc;
    span(0, 0, 1);
    chk("short_frame_err", 64'(o_sync_err), 64'd1);
    chk("short_frame_unlock", 64'(o_locked), 64'd0);
    chk("short_frame_no_fs", 64'(o_frame_start), 64'd0);
    span(0, 1, HT);
    for (int vv = 1; vv < VT; vv++) span(vv, 0, HT);
    span(0, 0, 1);
    chk("short_frame_relock", 64'(o_locked), 64'd1);
    chk("short_frame_err_count", 64'(err_acc - e0), 64'd1);

    // Frame 7: reset pulse mid-line while locked.
    span(0, 1, HT);
    span(1, 0, HT);
    span(2, 0, 300);
    e0  = err_acc;
    rst = 1'b1;
    #1;
    chk("rst_async_unlock", 64'(o_locked), 64'd0);
    for (int hh = 300; hh < 305; hh++) begin
      tick(1'b0, 1'b0, 3'b111);
      chk("rst_mid_frame_outputs", 64'(outs()), 64'd0);
    end
    rst = 1'b0;
    span(2, 305, HT);
    for (int vv = 3; vv < VT; vv++) span(vv, 0, HT);
    span(0, 0, 1);
    chk("rst_relock", 64'(o_locked), 64'd1);
    chk("rst_no_err", 64'(err_acc - e0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 Parameter H_TOTAL, 800, expected pixel clocks per line (hsync rise to hsync rise).
REQ-002 Parameter V_TOTAL, 526, expected lines per frame (vsync rise to vsync rise).
REQ-003 Parameter H_ACT_START, 145 / H_ACT_W, 639, first active pixel offset from hsync rise and active width.
REQ-004 Parameter V_ACT_START, 36 / V_ACT_H, 479, first active line offset from vsync rise and active height.
REQ-005 Parameter LOCK_LINES, 4, consecutive correct lines required before lock.
REQ-006 clk  input  1  pixel clock (25 MHz), the single clock.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 i_hsync / i_vsync  input  1 each  active-high syncs.
REQ-009 i_red / i_green / i_blue  input  1 each  colour samples.
REQ-010 o_pix_valid  output  1  current output pixel lies in the active window and the receiver is locked.
REQ-011 o_pix_x / o_pix_y  output  10 each  active-area coordinates, 0-based.
REQ-012 o_red / o_green / o_blue  output  1 each  colour, forced to 0 when o_pix_valid=0.
REQ-013 o_locked  output  1  timing lock indicator.
REQ-014 o_frame_start  output  1  one-cycle pulse on each vsync rise while locked.
REQ-015 o_sync_err  output  1  one-cycle pulse on every detected timing violation.
REQ-016 o_line_len  output  10  last measured line length, saturating at 1023.

Function
REQ-017 The rising edge of i_hsync SHALL reset h_cnt to 0; otherwise h_cnt increments, saturating at 1023.
REQ-018 The rising edge of i_vsync SHALL reset v_cnt to 0; otherwise v_cnt increments on each hsync rise, saturating at 1023; coincident vsync and hsync rises give v_cnt=0.
REQ-019 On each hsync rise, o_line_len SHALL capture h_cnt+1 (saturated).
REQ-020 FSM states: SEARCH, WAIT_VS, LOCKED; reset state SEARCH.
REQ-021 SEARCH: count consecutive hsync periods equal to H_TOTAL; a mismatch clears the count; at LOCK_LINES -> WAIT_VS.
REQ-022 WAIT_VS: the next vsync rise -> LOCKED, with o_frame_start pulsed that cycle; a line mismatch -> SEARCH.
REQ-023 LOCKED: any line period != H_TOTAL, h_cnt reaching 1023, or a vsync rise at v_cnt != V_TOTAL-1 -> SEARCH, with o_sync_err pulsed in the same cycle o_locked falls.
REQ-024 o_sync_err SHALL also pulse on a mismatch in SEARCH or WAIT_VS; it SHALL NOT pulse on the first hsync after reset.
REQ-025 Active window: H_ACT_START <= h_cnt < H_ACT_START+H_ACT_W and V_ACT_START <= v_cnt < V_ACT_START+V_ACT_H; o_pix_x = h_cnt-H_ACT_START and o_pix_y = v_cnt-V_ACT_START, else 0.
REQ-026 Latency: all outputs are registered, with 1 clk from input sample to output (without the macro).
REQ-027 A sync pulse longer than one line SHALL be treated as a single edge; only rising edges matter.

Reset
REQ-028 While rst=1, all outputs SHALL be 0, counters 0, FSM SEARCH, lock count 0, edge-detector history 0.
REQ-029 A reset asserted mid-frame SHALL drop o_locked within the reset assertion, with no o_sync_err pulse.

Configuration
REQ-030 Macro VGA_RX_INPUT_SYNC_EN defined: all five inputs pass through 2-flop synchronizers, input-to-output latency becomes 3 clk, and synchronizer flops reset to 0.
REQ-031 Macro undefined: inputs are sampled directly, with latency 1 clk and no added flops.

Structure
REQ-032 Package vga_rx_pkg SHALL hold the FSM state enum and default timing constants (800, 526, 96, 2, 145, 639, 36, 479).
REQ-033 One sub-module, vga_edge_det, SHALL provide optional synchronization plus a registered rising-edge pulse, instantiated for hsync and vsync.

Verification
REQ-034 Ideal 800x526 stream from reset: o_locked=1 at the first vsync rise after 4 good lines; o_frame_start pulses once per 420800 clk.
REQ-035 Locked stream: pixel at h_cnt=145, v_cnt=36 with rgb=111 -> o_pix_valid=1, x=0, y=0, rgb=111 one clk later; at h_cnt=784 -> o_pix_valid=0 and rgb=000.
REQ-036 One 799-clk line while locked -> o_sync_err pulse, o_locked=0, o_line_len=799; relock after 4 good lines plus vsync.
REQ-037 hsync held low 1100 clk -> h_cnt saturates at 1023, o_sync_err pulses once, and o_locked=0.
REQ-038 Frame with 525 lines -> o_sync_err at the early vsync rise and lock lost; rst pulse mid-frame -> all outputs 0 and no error pulse.
